// File: rtl/johnson_counter.sv
// Johnson (twisted-ring) counter: 2*WIDTH one-bit-change states, with
// direction control, synchronous clear, validated parallel load, a decoded
// state index and a one-cycle wrap pulse.
module johnson_counter #(
  parameter int WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              up,
  input  logic                              clr,
  input  logic                              load,
  input  logic [WIDTH-1:0]                  load_val,
  output logic [WIDTH-1:0]                  count,
  output logic [$clog2(2*WIDTH)-1:0]        state_idx,
  output logic                              wrap,
  output logic                              load_err
);

  localparam int IDXW = $clog2(2*WIDTH);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic [IDXW-1:0]  bit_edges;
  logic             load_legal;
  logic [IDXW-1:0]  ones;

  // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    bit_edges = '0;
    for (int i = 0; i < WIDTH-1; i++) begin
      bit_edges = bit_edges + IDXW'(load_val[i] ^ load_val[i+1]);
    end
    load_legal = (bit_edges <= IDXW'(1));
  end

  // Next-state selection with clr > load > en > hold priority.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_legal) begin
        count_d = load_val;
      end else begin
        count_d    = '0;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        count_d = {~count_q[0], count_q[WIDTH-1:1]};
        // last state (only LSB set) rolls over to all-zeros
        wrap_d  = (count_q == WIDTH'(1));
      end else begin
        count_d = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
        wrap_d  = (count_q == '0);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Index decode: count is always a legal code, so the number of ones plus
  // the MSB tells which half of the ring we are in.
  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IDXW'(count_q[i]);
    end
    if (count_q[WIDTH-1] || (ones == '0)) begin
      state_idx = ones;
    end else begin
      // truncation keeps this correct when 2*WIDTH is a power of two
      state_idx = IDXW'(2*WIDTH) - ones;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_johnson_counter.sv
// Directed bench for johnson_counter (WIDTH=4) with hand-computed vectors.
module tb_johnson_counter;

  logic       clk;
  logic       reset;
  logic       en, up, clr, load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [2:0] state_idx;
  logic       wrap, load_err;

  int n_checks = 0;
  int n_errors = 0;

  johnson_counter #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .up        (up),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .state_idx (state_idx),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // advance one clock, sample at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] c, input logic [2:0] idx,
                           input logic w, input logic le);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".idx"}, 32'(state_idx), 32'(idx));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  logic [3:0] fwd_cnt [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                              4'b0111, 4'b0011, 4'b0001, 4'b0000};
  logic [2:0] fwd_idx [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

  initial begin
    reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 4'b0000, 3'd0, 1'b0, 1'b0);

    // forward full cycle
    reset = 1'b1; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_state($sformatf("fwd%0d", i), fwd_cnt[i], fwd_idx[i], (i == 7), 1'b0);
    end

    // reverse from 0000
    up = 1'b0;
    step(); chk_state("rev0", 4'b0001, 3'd7, 1'b1, 1'b0);
    step(); chk_state("rev1", 4'b0011, 3'd6, 1'b0, 1'b0);
    step(); chk_state("rev2", 4'b0111, 3'd5, 1'b0, 1'b0);
    step(); chk_state("rev3", 4'b1111, 3'd4, 1'b0, 1'b0);
    step(); chk_state("rev4", 4'b1110, 3'd3, 1'b0, 1'b0);

    // hold with en low
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("hold%0d", i), 4'b1110, 3'd3, 1'b0, 1'b0);
    end
    en = 1'b1; up = 1'b1;
    step(); chk_state("reen", 4'b1111, 3'd4, 1'b0, 1'b0);

    // direction change mid-sequence: 1111 -> 1110 -> 1100 (rev), then fwd... use 1100 -> 1000
    up = 1'b0;
    step(); chk_state("dir0", 4'b1110, 3'd3, 1'b0, 1'b0);
    step(); chk_state("dir1", 4'b1100, 3'd2, 1'b0, 1'b0);
    step(); chk_state("dir2", 4'b1000, 3'd1, 1'b0, 1'b0);
    up = 1'b1;
    step(); chk_state("dir3", 4'b1100, 3'd2, 1'b0, 1'b0);

    // loads (load beats en)
    load = 1'b1; load_val = 4'b0111;
    step(); chk_state("ld_ok", 4'b0111, 3'd5, 1'b0, 1'b0);
    load_val = 4'b0101;
    step(); chk_state("ld_bad", 4'b0000, 3'd0, 1'b0, 1'b1);
    load = 1'b0; en = 1'b0;
    step(); chk_state("ld_err_clr", 4'b0000, 3'd0, 1'b0, 1'b0);
    load = 1'b1; load_val = 4'b1111;
    step(); chk_state("ld_1111", 4'b1111, 3'd4, 1'b0, 1'b0);

    // clr beats load
    clr = 1'b1; load_val = 4'b0011;
    step(); chk_state("clr_ld", 4'b0000, 3'd0, 1'b0, 1'b0);
    clr = 1'b0;

    // clr with en and reverse from 0 gives no wrap
    clr = 1'b1; load = 1'b0; en = 1'b1; up = 1'b0;
    step(); chk_state("clr_en", 4'b0000, 3'd0, 1'b0, 1'b0);
    clr = 1'b0; en = 1'b0; up = 1'b1;

    // async reset between edges
    load = 1'b1; load_val = 4'b0011;
    step(); chk_state("ld_0011", 4'b0011, 3'd6, 1'b0, 1'b0);
    load = 1'b0;
    #2 reset = 1'b0;
    #1 chk_state("async_rst", 4'b0000, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1; en = 1'b1; up = 1'b1;
    step(); chk_state("post_rst", 4'b1000, 3'd1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/johnson_counter.md
Name: johnson_counter

Overview:
Parameterised Johnson (twisted-ring) counter with 2*WIDTH states per cycle. It supports enable, up/down direction, synchronous clear and parallel load with code validation. It also provides a decoded state index and a wrap pulse. It is used as a glitch-free phase/sequence generator; each step changes exactly one bit of count.

Parameters:
WIDTH, 4, number of count bits (>=2); sequence length is 2*WIDTH states.
IDXW, $clog2(2*WIDTH), width of state_idx (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (asserted when 0).
en  input  1  count enable; one step per clk when high.
up  input  1  direction: 1 = forward sequence, 0 = reverse.
clr  input  1  synchronous clear to state 0.
load  input  1  synchronous parallel load of load_val.
load_val  input  WIDTH  value to load; must be a legal Johnson code.
count  output  WIDTH  registered Johnson code.
state_idx  output  IDXW  index 0..2*WIDTH-1 of the current count.
wrap  output  1  registered one-cycle pulse on sequence wrap.
load_err  output  1  registered one-cycle pulse when load_val was illegal.

Behaviour:
- Reset (reset=0, asynchronous): count=0, wrap=0, load_err=0. state_idx=0 follows from count.
- Reset release: the first step occurs on the first rising clk with reset=1 and en=1.
- Forward step (up=1): count_next = {~count[0], count[WIDTH-1:1]}. Shift right, MSB takes the inverted LSB.
- Forward sequence, WIDTH=4: 0000,1000,1100,1110,1111,0111,0011,0001, then back to 0000.
- Reverse step (up=0): count_next = {count[WIDTH-2:0], ~count[WIDTH-1]}. This is the exact inverse of the forward step; 0000 -> 0001 -> 0011 ...
- Priority per clock: clr > load > en > hold.
- clr=1: count=0; wrap=0; load_err=0.
- load=1: if load_val is legal, count=load_val and load_err=0. If illegal, count=0 and load_err=1 for one cycle. wrap=0.
- Legal code: one of the 2*WIDTH sequence values, i.e. a run of ones from the MSB end or from the LSB end, including all-0 and all-1.
- en=0 with no clr/load: count holds; wrap=0; load_err=0.
- state_idx decode, combinational from count:
  - all zeros = 0.
  - k leading ones from the MSB (k=1..WIDTH) = k.
  - k trailing ones from the LSB with zeros above (k=1..WIDTH-1) = 2*WIDTH-k.
  - For WIDTH=4: 1111=4, 0111=5, 0001=7.
- wrap: set to 1 for exactly the cycle after an enabled step from index 2*WIDTH-1 to 0 (up=1), or from 0 to 2*WIDTH-1 (up=0). Otherwise 0.
- Direction change mid-sequence takes effect on the next enabled step with no skipped states. Example: at 1100, up=0 gives 1000.
- Reset mid-operation forces all outputs to reset values immediately, independent of clk.
- Exactly one bit of count changes per enabled step, forward or reverse.

Test Plan:
- Reset 0 for 2 cycles, then 1, en=1, up=1, 8 clocks -> count 1000,1100,1110,1111,0111,0011,0001,0000; state_idx 1..7,0; wrap=1 only on the cycle count returns to 0000.
- From 0000, up=0, en=1, 3 clocks -> count 0001,0011,0111; state_idx 7,6,5; wrap=1 on the first step only.
- Count to 1110, drop en for 4 cycles -> count holds 1110, wrap=0. Re-enable -> 1111.
- load=1, load_val=0111 -> count=0111, state_idx=5, load_err=0. Then load_val=0101 -> count=0000, load_err=1 for one cycle.
- At 1111 assert clr and load together (load_val=0011) -> count=0000 (clr wins).
- Assert reset=0 asynchronously between clk edges while count=0011 -> count=0000 immediately. Deassert; next enabled clock -> 1000.
